// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: derives the per-register stall bus
// from stage requests and sequences exception/eret redirects through a flush.
module pipe_ctrl #(
  parameter logic [31:0] EXCP_ENTRY = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_dc,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic        excp_eret,
  input  logic [31:0] excp_pc,
  output logic [7:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] epc,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] epc_q;
  logic        eret_q;
  logic [31:0] cnt_q;
  logic        accept;
  logic [7:0]  req_mask;

  // Highest requesting stage wins; every register below it must freeze too.
  always_comb begin
    req_mask = '0;
    if (stallreq_if)  req_mask = 8'h07;
    if (stallreq_id)  req_mask = 8'h0F;
    if (stallreq_ex)  req_mask = 8'h1F;
    if (stallreq_dc)  req_mask = 8'h7F;
    if (stallreq_mem) req_mask = 8'hFF;
  end

  always_comb begin
    state_d = state_q;
    stall   = '0;
    flush   = 1'b0;
    new_pc  = '0;
    accept  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (excp_valid) begin
          stall   = '1;
          accept  = 1'b1;
          state_d = stallreq_mem ? HOLD : FLUSH;
        end else begin
          stall = req_mask;
        end
      end
      HOLD: begin
        stall = '1;
        if (!stallreq_mem) state_d = FLUSH;
      end
      FLUSH: begin
        flush   = 1'b1;
        new_pc  = eret_q ? epc_q : EXCP_ENTRY;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    // Reset overrides everything, including any pending redirect.
    if (rst) begin
      state_d = RUN;
      stall   = '0;
      flush   = 1'b0;
      new_pc  = '0;
      accept  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      epc_q   <= '0;
      eret_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        eret_q <= excp_eret;
        if (!excp_eret) epc_q <= excp_pc;
      end
      if (stall != 8'h00) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign epc          = epc_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a transaction-level model checked every cycle,
// plus literal expectations on the key scenarios.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_dc, stallreq_mem;
  logic        excp_valid, excp_eret;
  logic [31:0] excp_pc;
  logic [7:0]  stall;
  logic        flush;
  logic [31:0] new_pc, epc, stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl #(.EXCP_ENTRY(32'hBFC00380)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .stallreq_dc(stallreq_dc), .stallreq_mem(stallreq_mem),
    .excp_valid(excp_valid), .excp_eret(excp_eret), .excp_pc(excp_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .epc(epc),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Stall bus from stage indices: freeze every register up to the highest requester.
  function automatic logic [7:0] prefix_mask(input logic [4:0] reqs);
    int idx [5] = '{2, 3, 4, 6, 7};
    int k = -1;
    for (int i = 0; i < 5; i++)
      if (reqs[i] && idx[i] > k) k = idx[i];
    if (k < 0) return 8'h00;
    return 8'((1 << (k + 1)) - 1);
  endfunction

  // Model: a pending redirect is either waiting on memory or due this cycle.
  logic        m_wait = 1'b0, m_due = 1'b0, m_eret = 1'b0;
  logic [31:0] m_epc = '0, m_cnt = '0;

  always @(negedge clk) begin
    logic [7:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    e_stall = 8'h00; e_flush = 1'b0; e_pc = 32'h0;
    if (rst) begin
      // outputs quiet
    end else if (m_due) begin
      e_flush = 1'b1;
      e_pc    = m_eret ? m_epc : 32'hBFC00380;
    end else if (m_wait || excp_valid) begin
      e_stall = 8'hFF;
    end else begin
      e_stall = prefix_mask({stallreq_mem, stallreq_dc, stallreq_ex, stallreq_id, stallreq_if});
    end

    check("m_stall", {24'h0, stall}, {24'h0, e_stall});
    check("m_flush", {31'h0, flush}, {31'h0, e_flush});
    check("m_new_pc", new_pc, e_pc);
    check("m_epc", epc, m_epc);
    check("m_stall_cycles", stall_cycles, m_cnt);
    check("m_monotonic", {24'h0, stall & (stall + 8'd1)}, 32'h0);

    if (rst) begin
      m_wait = 1'b0; m_due = 1'b0; m_eret = 1'b0; m_epc = '0; m_cnt = '0;
    end else begin
      if (e_stall != 8'h00) m_cnt = m_cnt + 32'd1;
      if (m_due) begin
        m_due = 1'b0;
      end else if (m_wait) begin
        if (!stallreq_mem) begin m_wait = 1'b0; m_due = 1'b1; end
      end else if (excp_valid) begin
        m_eret = excp_eret;
        if (!excp_eret) m_epc = excp_pc;
        if (stallreq_mem) m_wait = 1'b1; else m_due = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic set_req(input logic f, input logic d, input logic e, input logic c, input logic m);
    stallreq_if = f; stallreq_id = d; stallreq_ex = e; stallreq_dc = c; stallreq_mem = m;
  endtask

  task automatic set_excp(input logic v, input logic r, input logic [31:0] pc);
    excp_valid = v; excp_eret = r; excp_pc = pc;
  endtask

  initial begin
    rst = 1'b1;
    set_req(0, 0, 0, 0, 0);
    set_excp(0, 0, 32'h0);
    sample();
    check("rst_stall", {24'h0, stall}, 32'h0);
    check("rst_flush", {31'h0, flush}, 32'h0);
    check("rst_new_pc", new_pc, 32'h0);
    cyc();
    sample();
    check("rst_cnt", stall_cycles, 32'h0);
    check("rst_epc", epc, 32'h0);
    cyc(); rst = 1'b0;

    set_req(0, 0, 0, 1, 0); sample(); check("dc_only", {24'h0, stall}, 32'h7F);
    cyc(); set_req(0, 0, 0, 1, 1); sample(); check("dc_mem", {24'h0, stall}, 32'hFF);
    cyc(); set_req(0, 0, 0, 0, 0); sample(); check("none", {24'h0, stall}, 32'h00);
    cyc(); set_req(1, 0, 0, 0, 0); sample(); check("if_only", {24'h0, stall}, 32'h07);
    cyc(); set_req(0, 1, 1, 0, 0); sample(); check("id_ex", {24'h0, stall}, 32'h1F);
    cyc(); set_req(0, 0, 0, 0, 0); sample(); check("cnt_after_reqs", stall_cycles, 32'd4);

    // Exception with no stalls, priority over a same-cycle request.
    cyc(); set_req(1, 0, 0, 0, 0); set_excp(1, 0, 32'h80001234);
    sample(); check("excp_stall", {24'h0, stall}, 32'hFF);
    check("excp_noflush", {31'h0, flush}, 32'h0);
    cyc(); set_req(0, 0, 0, 0, 0); set_excp(0, 0, 32'h0);
    sample(); check("excp_flush", {31'h0, flush}, 32'h1);
    check("excp_new_pc", new_pc, 32'hBFC00380);
    check("excp_epc", epc, 32'h80001234);
    check("flush_stall", {24'h0, stall}, 32'h00);
    cyc(); sample(); check("excp_flush_end", {31'h0, flush}, 32'h0);
    check("idle_new_pc", new_pc, 32'h0);

    // Exception while memory busy: hold three cycles, flush after mem drops.
    cyc(); set_req(0, 0, 0, 0, 1); set_excp(1, 0, 32'h80000010);
    sample(); check("hold1_stall", {24'h0, stall}, 32'hFF);
    cyc(); set_excp(1, 1, 32'hDEAD0000);
    sample(); check("hold2_stall", {24'h0, stall}, 32'hFF);
    check("hold2_flush", {31'h0, flush}, 32'h0);
    cyc(); set_excp(0, 0, 32'h0);
    sample(); check("hold3_stall", {24'h0, stall}, 32'hFF);
    check("hold3_flush", {31'h0, flush}, 32'h0);
    cyc(); set_req(0, 0, 0, 0, 0);
    sample(); check("hold_release_flush", {31'h0, flush}, 32'h0);
    cyc(); sample();
    check("hold_flush", {31'h0, flush}, 32'h1);
    check("hold_new_pc", new_pc, 32'hBFC00380);
    check("hold_epc", epc, 32'h80000010);

    // Eret returns to latched epc without overwriting it.
    cyc(); set_excp(1, 1, 32'hDEADBEEF);
    sample(); check("eret_stall", {24'h0, stall}, 32'hFF);
    cyc(); set_excp(0, 0, 32'h0);
    sample(); check("eret_flush", {31'h0, flush}, 32'h1);
    check("eret_new_pc", new_pc, 32'h80000010);
    check("eret_epc", epc, 32'h80000010);

    // excp_valid held through the flush cycle yields a single pulse.
    cyc(); set_excp(1, 0, 32'h80002000);
    sample(); check("held_stall", {24'h0, stall}, 32'hFF);
    cyc();
    sample(); check("held_flush", {31'h0, flush}, 32'h1);
    check("held_new_pc", new_pc, 32'hBFC00380);
    cyc(); set_excp(0, 0, 32'h0);
    sample(); check("held_single", {31'h0, flush}, 32'h0);
    check("held_epc", epc, 32'h80002000);

    // Reset during HOLD drops the pending redirect.
    cyc(); set_req(0, 0, 0, 0, 1); set_excp(1, 0, 32'h80003000);
    sample(); check("rh_stall", {24'h0, stall}, 32'hFF);
    cyc(); set_excp(0, 0, 32'h0);
    sample(); check("rh_hold", {24'h0, stall}, 32'hFF);
    cyc(); rst = 1'b1;
    sample(); check("rh_rst_stall", {24'h0, stall}, 32'h0);
    cyc(); rst = 1'b0; set_req(0, 0, 0, 0, 0);
    sample(); check("rh_noflush", {31'h0, flush}, 32'h0);
    check("rh_cnt", stall_cycles, 32'h0);
    check("rh_epc", epc, 32'h0);
    cyc(); sample(); check("rh_noflush2", {31'h0, flush}, 32'h0);
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter EXCP_ENTRY, default 32'hBFC00380, exception handler entry address.
REQ-002 SHALL have port clk  in  1  clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port stallreq_if  in  1  stall request from stage index 2 (fetch return).
REQ-005 SHALL have port stallreq_id  in  1  stall request from stage index 3 (decode, load-use).
REQ-006 SHALL have port stallreq_ex  in  1  stall request from stage index 4 (multi-cycle ALU).
REQ-007 SHALL have port stallreq_dc  in  1  stall request from stage index 6 (data cache miss).
REQ-008 SHALL have port stallreq_mem  in  1  stall request from stage index 7; memory transaction outstanding.
REQ-009 SHALL have port excp_valid  in  1  exception or eret presented by the mem stage.
REQ-010 SHALL have port excp_eret  in  1  qualifies excp_valid as eret; ignored unless excp_valid=1.
REQ-011 SHALL have port excp_pc  in  32  pc of the excepting instruction.
REQ-012 SHALL have port stall  out  8  StallBus; bit i = 1 (Stop) freezes pipeline register i.
REQ-013 SHALL have port flush  out  1  clears all pipeline registers at the next edge.
REQ-014 SHALL have port new_pc  out  32  redirect target; valid only while flush=1.
REQ-015 SHALL have port epc  out  32  last latched exception pc.
REQ-016 SHALL have port stall_cycles  out  32  count of cycles with stall != 0.

Function
REQ-017 SHALL run FSM with states RUN, HOLD, FLUSH.
REQ-018 SHALL, in RUN with excp_valid=0, drive stall[k:0]=1 and stall[7:k+1]=0, where k is the highest index among asserted requests; all requests low -> stall=8'h00.
REQ-019 SHALL make stall monotonic: a set bit i implies bits i-1..0 are set, in every state.
REQ-020 SHALL, in RUN with excp_valid=1 and stallreq_mem=0, drive stall=8'hFF that cycle, latch excp_pc/excp_eret, and enter FLUSH.
REQ-021 SHALL, in RUN with excp_valid=1 and stallreq_mem=1, drive stall=8'hFF, latch excp_pc/excp_eret, and enter HOLD.
REQ-022 SHALL, in HOLD, drive stall=8'hFF and ignore excp_valid; enter FLUSH on the first cycle stallreq_mem=0.
REQ-023 SHALL, in FLUSH, drive flush=1 and stall=8'h00 for exactly one cycle, then return to RUN.
REQ-024 SHALL, in FLUSH, set new_pc=epc if latched eret=1, else EXCP_ENTRY.
REQ-025 SHALL update epc only on non-eret acceptance (REQ-020/021), with the value excp_pc.
REQ-026 SHALL ignore excp_valid while in FLUSH, because the source instruction is being flushed.
REQ-027 SHALL drive flush=0 in RUN and HOLD; new_pc SHALL be 32'h0 when flush=0.
REQ-028 SHALL increment stall_cycles every cycle stall != 0, wrapping 32'hFFFFFFFF -> 0.
REQ-029 SHALL give excp_valid priority over all stall requests in the same cycle.
REQ-030 SHALL derive stall and flush combinationally from state and inputs; state, epc, latches and counter SHALL be registered.

Reset
REQ-031 SHALL, on rst=1, force state RUN, epc=0, the latched eret flag to 0, and stall_cycles=0.
REQ-032 SHALL hold outputs stall=8'h00, flush=0, new_pc=0 during rst.
REQ-033 SHALL, when rst is asserted in HOLD or FLUSH, discard the pending redirect; there is no flush after reset release.

Verification
REQ-034 SHALL cover: stallreq_dc=1 only -> stall=8'h7F; add stallreq_mem=1 -> stall=8'hFF; all low -> 8'h00.
REQ-035 SHALL cover: excp_valid=1, excp_pc=32'h80001234, eret=0, no stalls -> stall=8'hFF that cycle; next cycle flush=1, new_pc=32'hBFC00380, epc=32'h80001234; following cycle flush=0.
REQ-036 SHALL cover: excp_valid=1 with stallreq_mem=1 held 3 cycles -> stall=8'hFF for 3 cycles, flush=0 throughout; flush=1 on the cycle after stallreq_mem falls.
REQ-037 SHALL cover: exception at pc 32'h80000010, then eret -> second flush gives new_pc=32'h80000010, epc unchanged.
REQ-038 SHALL cover: excp_valid held high through FLUSH -> only one flush pulse; stall_cycles increments exactly on cycles with stall!=0.
REQ-039 SHALL cover: rst asserted during HOLD -> state RUN, flush never asserts, stall_cycles=0.
